// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage of the pipelined LEGv8 core. Holds
//                the PC, drives the instruction-memory address and registers
//                {instruction, PC, PC+4} into the IF/ID pipeline register.
//                Applies hazard stalls and branch redirects resolved further
//                down the pipe.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                stall             - hold PC and IF/ID this cycle
//                redirect          - taken branch resolved downstream
//                redirect_pc       - branch target (low 2 bits discarded)
//                imem_addr         - instruction-memory address (= PC)
//                imem_instr        - instruction at imem_addr, same cycle
//                pc_out            - current PC (debug/trace)
//                ifid_instr        - IF/ID instruction to decode
//                ifid_pc           - IF/ID address of ifid_instr
//                ifid_pc_plus4     - IF/ID ifid_pc+4 (BL link value)
//                ifid_valid        - IF/ID holds a real instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [ADDR_W-1:0]   ifid_pc_plus4,
    output logic                ifid_valid
);

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [ADDR_W-1:0]  r_ifid_pc;
    logic [ADDR_W-1:0]  r_ifid_pc_plus4;
    logic               r_ifid_valid;

    // Wraps modulo 2^ADDR_W; no overflow indication is wanted.
    logic [ADDR_W-1:0]  w_pc_plus4;
    // Branch targets are forced word-aligned.
    logic [ADDR_W-1:0]  w_redirect_aligned;

    assign w_pc_plus4         = r_pc + c_pc_step;
    assign w_redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Priority: reset > redirect > stall > advance. A redirect squashes
    // whatever was fetched this cycle, even while the hazard unit stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= '0;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (redirect) begin
            r_pc            <= w_redirect_aligned;
            r_ifid_instr    <= '0;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (!stall) begin
            r_pc            <= w_pc_plus4;
            r_ifid_instr    <= imem_instr;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
        end
        // stall without redirect: everything holds, same address refetched.
    end

    assign imem_addr     = r_pc;
    assign pc_out        = r_pc;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign ifid_valid    = r_ifid_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage (RESET_PC=0x100)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic [ADDR_W-1:0]  pc_out;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [ADDR_W-1:0]  ifid_pc_plus4;
    logic               ifid_valid;

    int r_checks;
    int r_failures;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (64'h100)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .pc_out        (pc_out),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_checks    = 0;
        r_failures  = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_instr  = '0;

        // Reset held for two cycles.
        step();
        step();
        check("rst_pc",        pc_out, 64'h100);
        check("rst_imem_addr", imem_addr, 64'h100);
        check("rst_valid",     64'(ifid_valid), 64'h0);
        check("rst_instr",     64'(ifid_instr), 64'h0);
        check("rst_ifid_pc",   ifid_pc, 64'h0);
        check("rst_plus4",     ifid_pc_plus4, 64'h0);

        // First advance after release.
        reset      = 1'b0;
        imem_instr = 32'h9100_0421;
        step();
        check("first_instr", 64'(ifid_instr), 64'h9100_0421);
        check("first_pc",    ifid_pc, 64'h100);
        check("first_plus4", ifid_pc_plus4, 64'h104);
        check("first_valid", 64'(ifid_valid), 64'h1);
        check("first_pcout", pc_out, 64'h104);

        // Redirect to 0 to start sequential fetch.
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        step();
        redirect = 1'b0;
        check("redir0_pc",    pc_out, 64'h0);
        check("redir0_valid", 64'(ifid_valid), 64'h0);

        // Four sequential advances from 0.
        for (int i = 0; i < 4; i++) begin
            imem_instr = 32'hD000_0000 | 32'(i);
            step();
            check("seq_ifid_pc", ifid_pc, 64'(4 * i));
            check("seq_plus4",   ifid_pc_plus4, 64'(4 * i + 4));
            check("seq_instr",   64'(ifid_instr), 64'(32'hD000_0000 | 32'(i)));
            check("seq_valid",   64'(ifid_valid), 64'h1);
            check("seq_pcout",   pc_out, 64'(4 * i + 4));
        end

        // Position at pc=0x8 with IF/ID holding address 0x4.
        redirect    = 1'b1;
        redirect_pc = 64'h4;
        step();
        redirect   = 1'b0;
        imem_instr = 32'hE000_0004;
        step();
        check("pre_stall_pc", pc_out, 64'h8);

        // Three stalled cycles: everything holds, imem ignored.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_instr = 32'hBAD0_0000 | 32'(i);
            step();
            check("stall_pc",    pc_out, 64'h8);
            check("stall_ifpc",  ifid_pc, 64'h4);
            check("stall_plus4", ifid_pc_plus4, 64'h8);
            check("stall_instr", 64'(ifid_instr), 64'hE000_0004);
            check("stall_valid", 64'(ifid_valid), 64'h1);
        end
        stall      = 1'b0;
        imem_instr = 32'hE000_0008;
        step();
        check("unstall_ifpc",  ifid_pc, 64'h8);
        check("unstall_instr", 64'(ifid_instr), 64'hE000_0008);
        check("unstall_pc",    pc_out, 64'hC);

        // Redirect with simultaneous stall: redirect wins.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        imem_instr  = 32'hDEAD_BEEF;
        step();
        check("rs_pc",    pc_out, 64'h40);
        check("rs_valid", 64'(ifid_valid), 64'h0);
        check("rs_instr", 64'(ifid_instr), 64'h0);
        check("rs_ifpc",  ifid_pc, 64'h0);
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_instr = 32'hF000_0040;
        step();
        check("rs_next_ifpc",  ifid_pc, 64'h40);
        check("rs_next_valid", 64'(ifid_valid), 64'h1);
        check("rs_next_pc",    pc_out, 64'h44);

        // Misaligned target is word-aligned.
        redirect    = 1'b1;
        redirect_pc = 64'h47;
        step();
        check("align_pc", pc_out, 64'h44);

        // Back-to-back redirects keep loading the newest target.
        redirect_pc = 64'h80;
        step();
        check("b2b1_pc",    pc_out, 64'h80);
        check("b2b1_valid", 64'(ifid_valid), 64'h0);
        redirect_pc = 64'h93;
        step();
        check("b2b2_pc",    pc_out, 64'h90);
        check("b2b2_valid", 64'(ifid_valid), 64'h0);

        // Wraparound at the top of the address space.
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("wrap_pre_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        redirect   = 1'b0;
        imem_instr = 32'h1234_5678;
        step();
        check("wrap_pc",    pc_out, 64'h0);
        check("wrap_ifpc",  ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_plus4", ifid_pc_plus4, 64'h0);
        check("wrap_instr", 64'(ifid_instr), 64'h1234_5678);

        // Reset beats simultaneous stall and redirect.
        reset       = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        step();
        check("rstwin_pc",    pc_out, 64'h100);
        check("rstwin_valid", 64'(ifid_valid), 64'h0);
        check("rstwin_instr", 64'(ifid_instr), 64'h0);
        check("rstwin_ifpc",  ifid_pc, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
